game_timer_lives: RTL and testbench

GAME_TIMER_LIVES -- requirements
Module: game_timer_lives

---
 rtl/game_pkg.sv | 25 ++
 rtl/sec_prescaler.sv | 60 ++++++
 rtl/game_timer_lives.sv | 112 +++++++++++
 tb/tb_game_timer_lives.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : game_pkg
//  Description : Shared defaults and helpers for the game timer / lives block.
//  Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Default timeout length in seconds.
    localparam int SECONDS_DEF    = 4;
    // Default value loaded into the lives counter.
    localparam int LIVES_INIT_DEF = 3;
    // Default width of the lives counter.
    localparam int LIVES_W_DEF    = 2;

    // Width needed for a counter that must be able to hold the value secs.
    function automatic int sec_width(input int secs);
        return (secs < 1) ? 1 : $clog2(secs + 1);
    endfunction

    // Seconds-counter width for the default timeout length.
    localparam int SEC_W = sec_width(SECONDS_DEF);

endpackage : game_pkg
`default_nettype wire

// File: rtl/sec_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : sec_prescaler
//  Description : Divides clk by N; emits a one-cycle tick on the wrap cycle.
//                Optional build macro TIMER_PAUSE_EN adds a pause input that
//                freezes the count (clr still wins over pause).
//  Revision    : 1.0  initial release
// ============================================================================
module sec_prescaler #(
    parameter int N = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
`ifdef TIMER_PAUSE_EN
    input  logic pause,
`endif
    output logic tick
);

    localparam int                 c_cnt_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(N - 1);

    logic [c_cnt_w-1:0] cnt_q;
    logic [c_cnt_w-1:0] cnt_d;
    logic               w_run;

`ifdef TIMER_PAUSE_EN
    assign w_run = ~pause;
`else
    assign w_run = 1'b1;
`endif

    // Next count: clear has priority, otherwise advance and wrap at N-1.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (w_run) begin
            if (cnt_q == c_last) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + c_cnt_w'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : sec_prescaler
`default_nettype wire

// File: rtl/game_timer_lives.sv
`default_nettype none
// ============================================================================
//  Module      : game_timer_lives
//  Description : Timeout timer (foursec) and lives counter serving a game FSM.
//                Build macro TIMER_PAUSE_EN adds a pause input for the timer.
//  Revision    : 1.0  initial release
// ============================================================================
module game_timer_lives
    import game_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int SECONDS       = SECONDS_DEF,
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int LIVES_W       = LIVES_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               resettimer,
    input  logic               loadlives,
    input  logic               decrementlives,
`ifdef TIMER_PAUSE_EN
    input  logic               pause,
`endif
    output logic               foursec,
    output logic               nolives,
    output logic [LIVES_W-1:0] lives
);

    localparam int                 c_sec_w      = sec_width(SECONDS);
    localparam logic [c_sec_w-1:0] c_sec_max    = c_sec_w'(SECONDS);
    localparam logic [LIVES_W-1:0] c_lives_init = LIVES_W'(LIVES_INIT);

    logic               w_tick;
    logic [c_sec_w-1:0] sec_q;
    logic [c_sec_w-1:0] sec_d;
    logic               foursec_q;
    logic               foursec_d;
    logic [LIVES_W-1:0] lives_q;
    logic [LIVES_W-1:0] lives_d;
    logic               dec_q;
    logic               w_dec_edge;

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    sec_prescaler #(
        .N     (TICKS_PER_SEC)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (resettimer),
`ifdef TIMER_PAUSE_EN
        .pause (pause),
`endif
        .tick  (w_tick)
    );

    // Seconds count saturates at SECONDS; resettimer beats a same-cycle tick.
    // foursec is registered from the next count so it tracks it exactly.
    always_comb begin
        sec_d = sec_q;
        if (resettimer) begin
            sec_d = '0;
        end else if (w_tick && (sec_q != c_sec_max)) begin
            sec_d = sec_q + c_sec_w'(1);
        end
        foursec_d = (sec_d == c_sec_max);
    end

    // Seconds counter and timeout flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q     <= '0;
            foursec_q <= 1'b0;
        end else begin
            sec_q     <= sec_d;
            foursec_q <= foursec_d;
        end
    end

    // ------------------------------------------------------------------
    // Lives
    // ------------------------------------------------------------------
    assign w_dec_edge = decrementlives & ~dec_q;

    // Load wins over a decrement edge; decrement saturates at zero.
    always_comb begin
        lives_d = lives_q;
        if (loadlives) begin
            lives_d = c_lives_init;
        end else if (w_dec_edge && (lives_q != '0)) begin
            lives_d = lives_q - LIVES_W'(1);
        end
    end

    // Lives register and decrement edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lives_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            lives_q <= lives_d;
            dec_q   <= decrementlives;
        end
    end

    assign foursec = foursec_q;
    assign lives   = lives_q;
    assign nolives = (lives_q == '0);

endmodule : game_timer_lives
`default_nettype wire

// File: tb/tb_game_timer_lives.sv
`default_nettype none
// ============================================================================
//  Module      : tb_game_timer_lives
//  Description : Self-checking bench for game_timer_lives (TICKS_PER_SEC=10).
//                Honours TIMER_PAUSE_EN when the design is built with it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_game_timer_lives;

    localparam int c_ticks = 10;

    logic       clk;
    logic       rst_n;
    logic       resettimer;
    logic       loadlives;
    logic       decrementlives;
    logic       pause;
    logic       foursec;
    logic       nolives;
    logic [1:0] lives;

    int checks   = 0;
    int failures = 0;

    game_timer_lives #(
        .TICKS_PER_SEC (c_ticks),
        .SECONDS       (4),
        .LIVES_INIT    (3),
        .LIVES_W       (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .resettimer     (resettimer),
        .loadlives      (loadlives),
        .decrementlives (decrementlives),
`ifdef TIMER_PAUSE_EN
        .pause          (pause),
`endif
        .foursec        (foursec),
        .nolives        (nolives),
        .lives          (lives)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rt;
        logic       ld;
        logic       dec;
        logic [1:0] exp_lives;
        logic       exp_nolives;
        logic       exp_foursec;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One active edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rt, input logic ld, input logic dec,
                       input logic [1:0] el, input logic en, input logic ef);
        vec_t v;
        v.rt = rt; v.ld = ld; v.dec = dec;
        v.exp_lives = el; v.exp_nolives = en; v.exp_foursec = ef;
        vecs.push_back(v);
    endtask

    // Restart the timer, then check foursec at every edge up to the rise.
    task automatic run_timer(input string name);
        resettimer = 1'b1;
        step();
        chk({name, "_clr"}, int'(foursec), 0);
        resettimer = 1'b0;
        for (int k = 1; k <= 4 * c_ticks; k++) begin
            step();
            chk(name, int'(foursec), (k == 4 * c_ticks) ? 1 : 0);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        resettimer     = 1'b0;
        loadlives      = 1'b0;
        decrementlives = 1'b0;
        pause          = 1'b0;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_foursec", int'(foursec), 0);
        chk("rst_lives",   int'(lives),   0);
        chk("rst_nolives", int'(nolives), 1);
        rst_n = 1'b1;
        step();
        chk("post_rst_lives",   int'(lives),   0);
        chk("post_rst_nolives", int'(nolives), 1);
        chk("post_rst_foursec", int'(foursec), 0);

        // ---------------- lives table ----------------
        //   rt  ld  dec  lives nolives foursec
        add(1, 0, 0, 2'd0, 1, 0);   // timer clear only, lives untouched
        add(0, 1, 0, 2'd3, 0, 0);   // load
        add(0, 0, 0, 2'd3, 0, 0);
        add(0, 0, 1, 2'd2, 0, 0);   // held high 5 cycles -> one decrement
        add(0, 0, 1, 2'd2, 0, 0);
        add(0, 0, 1, 2'd2, 0, 0);
        add(0, 0, 1, 2'd2, 0, 0);
        add(0, 0, 1, 2'd2, 0, 0);
        add(0, 0, 0, 2'd2, 0, 0);
        add(0, 0, 1, 2'd1, 0, 0);
        add(1, 0, 0, 2'd1, 0, 0);   // timer clear leaves lives alone
        add(0, 0, 1, 2'd0, 1, 0);
        add(0, 0, 0, 2'd0, 1, 0);
        add(0, 0, 1, 2'd0, 1, 0);   // saturate at zero
        add(0, 0, 0, 2'd0, 1, 0);
        add(0, 1, 0, 2'd3, 0, 0);
        add(0, 0, 1, 2'd2, 0, 0);
        add(0, 0, 0, 2'd2, 0, 0);
        add(0, 0, 1, 2'd1, 0, 0);
        add(0, 0, 0, 2'd1, 0, 0);
        add(0, 1, 1, 2'd3, 0, 0);   // load beats decrement edge
        add(0, 0, 1, 2'd3, 0, 0);   // still high: no new edge
        add(0, 0, 0, 2'd3, 0, 0);
        add(0, 0, 1, 2'd2, 0, 0);

        foreach (vecs[i]) begin
            resettimer     = vecs[i].rt;
            loadlives      = vecs[i].ld;
            decrementlives = vecs[i].dec;
            step();
            chk($sformatf("vec%0d_lives", i),   int'(lives),   int'(vecs[i].exp_lives));
            chk($sformatf("vec%0d_nolives", i), int'(nolives), int'(vecs[i].exp_nolives));
            chk($sformatf("vec%0d_foursec", i), int'(foursec), int'(vecs[i].exp_foursec));
        end
        resettimer     = 1'b0;
        loadlives      = 1'b0;
        decrementlives = 1'b0;

        // ---------------- timeout ----------------
        run_timer("timeout");
        for (int k = 0; k < 100; k++) begin
            step();
            chk("hold_high", int'(foursec), 1);
        end
        chk("timer_lives_untouched", int'(lives), 2);

        // ---------------- resettimer at count 25 ----------------
        resettimer = 1'b1;
        step();
        resettimer = 1'b0;
        repeat (25) step();
        chk("mid_count_low", int'(foursec), 0);
        run_timer("restart25");

        // ---------------- resettimer while foursec=1 ----------------
        step();
        chk("still_high", int'(foursec), 1);
        run_timer("restart_high");

`ifdef TIMER_PAUSE_EN
        // ---------------- pause delays the rise by 7 ----------------
        resettimer = 1'b1;
        step();
        resettimer = 1'b0;
        for (int k = 1; k <= 4 * c_ticks + 7; k++) begin
            pause = (k >= 11 && k <= 17);
            step();
            chk("pause_delay", int'(foursec), (k == 4 * c_ticks + 7) ? 1 : 0);
        end
        pause = 1'b0;
`endif

        // ---------------- async reset mid-operation ----------------
        loadlives = 1'b1;
        step();
        loadlives = 1'b0;
        chk("pre_rst_lives", int'(lives), 3);
        decrementlives = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_foursec", int'(foursec), 0);
        chk("async_rst_lives",   int'(lives),   0);
        chk("async_rst_nolives", int'(nolives), 1);
        decrementlives = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 4 * c_ticks; k++) begin
            step();
            chk("post_async_foursec", int'(foursec), (k == 4 * c_ticks) ? 1 : 0);
        end
        chk("post_async_lives", int'(lives), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_game_timer_lives
`default_nettype wire
